// File: rtl/mcycle_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// The op field packs "is divide" in bit 1 and "is unsigned" in bit 0.
package mcycle_pkg;

    typedef enum logic [1:0] {
        OP_SMUL = 2'b00,
        OP_UMUL = 2'b01,
        OP_SDIV = 2'b10,
        OP_UDIV = 2'b11
    } mcycle_op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_e;

    localparam int OP_DIV_BIT = 1;
    localparam int OP_UNS_BIT = 0;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[OP_DIV_BIT];
    endfunction

    function automatic logic op_is_unsigned(input logic [1:0] op);
        return op[OP_UNS_BIT];
    endfunction

endpackage

// File: rtl/mcycle_step.sv
// One combinational iteration: shift-add for multiply, restoring trial
// subtract for divide, both working on the {hi, lo} register pair.
module mcycle_step
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             div_op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        addend  = lo[0] ? operand : '0;
        sum     = {1'b0, hi} + {1'b0, addend};
        shifted = {hi, lo[WIDTH-1]};
        fits    = shifted >= {1'b0, operand};
        // The partial remainder stays below the divisor, so the difference fits in WIDTH bits.
        diff    = shifted[WIDTH-1:0] - operand;
        if (div_op) begin
            hi_next = fits ? diff : shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], fits};
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: one bit per cycle on operand magnitudes,
// sign fix-up and result registration on the final iteration.
module mcycle_unit
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int CW = $clog2(WIDTH);

    state_e           state, state_next;
    logic [CW-1:0]    count;
    logic             last;
    logic             accept;

    logic             div_op, neg_a, neg_b;
    logic             neg_a_in, neg_b_in;
    logic [WIDTH-1:0] hi, lo, operand_b, op1_raw;
    logic [WIDTH-1:0] hi_step, lo_step;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res1_next, res2_next;

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_negate_wide(input logic [2*WIDTH-1:0] x,
                                                            input logic neg);
        return neg ? -x : x;
    endfunction

    assign accept   = (state == IDLE) && Start;
    assign last     = (state == COMPUTE) && (count == CW'(WIDTH - 1));
    assign Busy     = accept || (state == COMPUTE);
    assign neg_a_in = !op_is_unsigned(MCycleOp) && Operand1[WIDTH-1];
    assign neg_b_in = !op_is_unsigned(MCycleOp) && Operand2[WIDTH-1];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = COMPUTE;
            COMPUTE: if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    mcycle_step #(.WIDTH(WIDTH)) u_step (
        .div_op  (div_op),
        .hi      (hi),
        .lo      (lo),
        .operand (operand_b),
        .hi_next (hi_step),
        .lo_next (lo_step)
    );

    // Sign fix-up applied to the final iteration's output; divide by zero bypasses it.
    always_comb begin
        prod      = cond_negate_wide({hi_step, lo_step}, neg_a ^ neg_b);
        res1_next = prod[WIDTH-1:0];
        res2_next = prod[2*WIDTH-1:WIDTH];
        if (div_op) begin
            if (operand_b == '0) begin
                res1_next = '1;
                res2_next = op1_raw;
            end else begin
                res1_next = cond_negate(lo_step, neg_a ^ neg_b);
                res2_next = cond_negate(hi_step, neg_a);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            count   <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE || last) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
            if (last) begin
                Result1 <= res1_next;
                Result2 <= res2_next;
            end
        end
    end

    // Operand capture and iteration registers carry data only.
    always_ff @(posedge CLK) begin
        if (accept) begin
            div_op    <= op_is_div(MCycleOp);
            neg_a     <= neg_a_in;
            neg_b     <= neg_b_in;
            op1_raw   <= Operand1;
            operand_b <= cond_negate(Operand2, neg_b_in);
            hi        <= '0;
            lo        <= cond_negate(Operand1, neg_a_in);
        end else if (state == COMPUTE) begin
            hi <= hi_step;
            lo <= lo_step;
        end
    end

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit with an arithmetic reference model checked every cycle.
module tb_mcycle_unit;
    import mcycle_pkg::*;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         Start = 1'b0;
    logic [1:0]   MCycleOp = 2'b00;
    logic [W-1:0] Operand1 = '0;
    logic [W-1:0] Operand2 = '0;
    logic [W-1:0] Result1, Result2;
    logic         Busy;

    int checks = 0;
    int errors = 0;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the op definitions.
    function automatic void model_op(input logic [1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     output logic [W-1:0] r1, output logic [W-1:0] r2);
        longint     sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r1 = '0;
        r2 = '0;
        case (op)
            OP_SMUL: begin
                p  = sa * sb;
                r1 = p[31:0];
                r2 = p[63:32];
            end
            OP_UMUL: begin
                p  = {32'b0, a} * {32'b0, b};
                r1 = p[31:0];
                r2 = p[63:32];
            end
            default: begin
                if (b == '0) begin
                    r1 = '1;
                    r2 = a;
                end else begin
                    if (op == OP_SDIV) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'({32'b0, a}) / longint'({32'b0, b});
                        r = longint'({32'b0, a}) % longint'({32'b0, b});
                    end
                    r1 = q[31:0];
                    r2 = r[31:0];
                end
            end
        endcase
    endfunction

    // Model: an accepted request occupies W further cycles, then results land.
    bit           model_live = 1'b0;
    int           m_left = 0;
    logic [W-1:0] exp_r1 = '0, exp_r2 = '0, pend_r1 = '0, pend_r2 = '0;

    always @(posedge CLK) begin
        if (RESET) begin
            model_live = 1'b1;
            m_left     = 0;
            exp_r1     = '0;
            exp_r2     = '0;
        end else if (m_left == 0) begin
            if (Start) begin
                model_op(MCycleOp, Operand1, Operand2, pend_r1, pend_r2);
                m_left = W;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                exp_r1 = pend_r1;
                exp_r2 = pend_r2;
            end
        end
    end

    always @(negedge CLK) begin
        if (model_live) begin
            check("busy_model", {31'b0, Busy}, {31'b0, (m_left != 0) || Start});
            check("result1_model", Result1, exp_r1);
            check("result2_model", Result2, exp_r2);
        end
    end

    // Raise Start for one cycle, then scramble the inputs to prove they were latched.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output int busy0);
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        @(negedge CLK);
        busy0 = Busy ? 1 : 0;
        @(posedge CLK);
        #1;
        Start    = 1'b0;
        MCycleOp = ~op;
        Operand1 = $urandom;
        Operand2 = $urandom;
    endtask

    task automatic wait_idle(output int n);
        bit done;
        done = 1'b0;
        n    = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (!Busy) begin
                done = 1'b1;
                break;
            end
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL busy_timeout: Busy still high after %0d cycles, expected low", n);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e1,
                          input logic [W-1:0] e2);
        int b0, n;
        start_op(op, a, b, b0);
        wait_idle(n);
        check({name, "_busy_len"}, W'(b0 + n), W'(W + 1));
        check({name, "_r1"}, Result1, e1);
        check({name, "_r2"}, Result2, e2);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int b0, n;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("reset_busy", {31'b0, Busy}, '0);
        check("reset_r1", Result1, '0);
        check("reset_r2", Result2, '0);
        @(posedge CLK);
        #1;

        run_op("umul_max", OP_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("smul_neg", OP_SMUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
        run_op("smul_min", OP_SMUL, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000);
        run_op("udiv", OP_UDIV, 32'd100, 32'd7, 32'd14, 32'd2);
        run_op("sdiv_neg", OP_SDIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("sdiv_ovf", OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
        run_op("sdiv_zero", OP_SDIV, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
        run_op("udiv_zero", OP_UDIV, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);

        // Start pulses during COMPUTE must be ignored.
        start_op(OP_UDIV, 32'd1000, 32'd3, b0);
        repeat (4) @(posedge CLK);
        #1;
        Start = 1'b1; MCycleOp = OP_SMUL; Operand1 = 32'd5; Operand2 = 32'd5;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (14) @(posedge CLK);
        #1;
        Start = 1'b1; MCycleOp = OP_UMUL; Operand1 = 32'd11; Operand2 = 32'd13;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        wait_idle(n);
        check("ignore_r1", Result1, 32'd333);
        check("ignore_r2", Result2, 32'd1);
        @(posedge CLK);
        #1;

        // Back-to-back: Start held in the cycle Busy falls.
        start_op(OP_UMUL, 32'd6, 32'd7, b0);
        repeat (32) @(posedge CLK);
        #1;
        Start = 1'b1; MCycleOp = OP_SDIV; Operand1 = 32'hFFFF_FF9C; Operand2 = 32'd7;
        @(negedge CLK);
        check("b2b_first_r1", Result1, 32'd42);
        check("b2b_first_r2", Result2, 32'd0);
        check("b2b_busy", {31'b0, Busy}, 32'd1);
        @(posedge CLK);
        #1;
        Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom;
        wait_idle(n);
        check("b2b_len", W'(n), W'(W));
        check("b2b_second_r1", Result1, 32'hFFFF_FFF2);
        check("b2b_second_r2", Result2, 32'hFFFF_FFFE);
        @(posedge CLK);
        #1;

        // RESET in cycle 10 of a divide discards it.
        start_op(OP_UDIV, 32'd50000, 32'd13, b0);
        repeat (9) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_mid_busy", {31'b0, Busy}, '0);
        check("rst_mid_r1", Result1, '0);
        check("rst_mid_r2", Result2, '0);
        @(posedge CLK);
        #1;
        run_op("umul_9x9", OP_UMUL, 32'd9, 32'd9, 32'd81, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the processor's execute stage.
- Consumes the condition-qualified multi-cycle write strobe (M_Write, the condition-checked M_W) as its Start.
- Stalls fetch/decode via Busy while it iterates one bit per cycle.
- Returns a double-width product, or a quotient/remainder pair, for register write-back.

Parameters:
WIDTH, 32, operand and result width in bits; must be >= 4.

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
Start  input  1  condition-qualified request; sampled only in IDLE
MCycleOp  input  2  00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div
Operand1  input  WIDTH  multiplicand / dividend
Operand2  input  WIDTH  multiplier / divisor
Result1  output  WIDTH  product low half / quotient
Result2  output  WIDTH  product high half / remainder
Busy  output  1  stall request to pipeline

Behaviour:
- Reset values: state=IDLE, count=0, Result1=0, Result2=0, Busy=0.
- RESET has priority over every other event.
- States:
  - IDLE: Start=1 -> COMPUTE. Operands and op are latched at that edge, count=0.
  - COMPUTE: one iteration per cycle. At the edge where count==WIDTH-1, Result1/Result2 are registered and state -> IDLE. Otherwise count++.
- Busy = (state==IDLE & Start) | (state==COMPUTE).
  - The IDLE term is combinational, so the instruction issuing Start stalls in its own cycle.
- Latency: Busy is high for exactly WIDTH+1 consecutive cycles (33 at default).
  - Results are valid in the first cycle Busy is low again.
  - Results hold until the next completion or RESET.
- Start while in COMPUTE is ignored. Operand/op changes during COMPUTE have no effect.
- Start high in the cycle Busy falls (back in IDLE) begins a new operation with no idle gap.
- Multiply:
  - Shift-add on operand magnitudes, 2*WIDTH-bit accumulator.
  - Signed: the result is negated when the operand signs differ.
  - {Result2,Result1} = full 2*WIDTH-bit product.
- Divide:
  - Restoring shift-subtract on magnitudes.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed: the quotient is negated when the operand signs differ.
- Divide by zero: Result1 = all ones, Result2 = Operand1 as latched, for both signed and unsigned. Same latency; no exception.
- Signed overflow (-2^(WIDTH-1) / -1): Result1 = 0x80000000, Result2 = 0.
- Most-negative operand magnitude is handled in WIDTH+1-bit arithmetic; no internal overflow.
- RESET mid-COMPUTE: IDLE next cycle, results zeroed, the in-flight operation is discarded.

Decomposition:
- Shared package mcycle_pkg:
  - MCycleOp encodings (OP_SMUL, OP_UMUL, OP_SDIV, OP_UDIV).
  - State typedef {IDLE, COMPUTE}.
  - Helper constant for the is-divide bit (MCycleOp[1]) and the is-unsigned bit (MCycleOp[0]).
- One natural sub-module, mcycle_step: combinational single iteration.
  - Shift-add for multiply or trial subtract for divide.
  - Selected by the op bit; takes accumulator/operand registers and returns next values.
  - The parent owns the FSM, counter, sign fix-up and result registers.

Test Plan:
- Unsigned mul 0xFFFFFFFF*0xFFFFFFFF -> Result2=0xFFFFFFFE, Result1=0x00000001; Busy high exactly 33 cycles starting the Start cycle.
- Signed mul -3*7 -> Result2=0xFFFFFFFF, Result1=0xFFFFFFEB; signed mul 0x80000000*0x80000000 -> Result2=0x40000000, Result1=0.
- Unsigned div 100/7 -> Result1=14, Result2=2; signed div -7/2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF; signed div 0x80000000/-1 -> Result1=0x80000000, Result2=0.
- Divide by zero 0x1234/0 (both ops 10 and 11) -> Result1=0xFFFFFFFF, Result2=0x00001234 after 33 Busy cycles.
- Start pulsed again, with new operands, at cycles 5 and 20 of an operation -> ignored, original result delivered; Start held in the cycle Busy falls -> second op begins, back-to-back results correct.
- RESET asserted at cycle 10 of a divide -> next cycle Busy=0, Result1=Result2=0; subsequent 9*9 unsigned mul returns 81/0.
